vme_cmd_responder: RTL
======================

Name: vme_cmd_responder

Overview:
- Device-side end of the simulation VME command channel.
- Accepts one command word and one data word per `start` pulse from the command source. Decodes board address, read/write and device/register fields, then runs a strobe/ack cycle on the internal device register bus.
- Returns read data, or echoes write data, with a one-cycle `vme_dat_wr` pulse.
- Paces the source with `vme_cmd_rd`. Synthesizable; sits between the VME front end (or bench driver) and the device register files.

Parameters:
- BOARD_ADDR, 8'hA8: value required in `vme_cmd_reg[23:16]` for a command to be executed.
- TIMEOUT_CYCLES, 255: maximum cycles waited for `dev_ack` after `dev_strobe` rises.
- HOLDOFF_CYCLES, 2: idle cycles between the response pulse and re-assertion of `vme_cmd_rd`; minimum 1.
- TIMEOUT_DATA, 16'hDEAD: data returned on timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  command valid; sampled only while `vme_cmd_rd`=1
- vme_cmd_reg  in  32  [25] read, [24] write, [23:16] board address, [15:12] device, [11:0] register offset
- vme_dat_reg_in  in  32  write data in [15:0]; [31:16] ignored
- vme_cmd_rd  out  1  ready for next command
- vme_dat_wr  out  1  one-cycle response strobe
- vme_dat_reg_out  out  32  [31] timeout flag, [30:16] zero, [15:0] read data or echoed write data
- dev_sel  out  16  one-hot device select, decoded from [15:12]
- dev_addr  out  12  register offset
- dev_wr  out  1  1 = write cycle
- dev_strobe  out  1  bus cycle active
- dev_wdata  out  16  write data
- dev_rdata  in  16  read data, valid with `dev_ack`
- dev_ack  in  1  cycle complete
- err_count  out  8  saturating count of timeouts plus address mismatches

Behaviour:
- Reset (synchronous, `rst`=1):
  - All outputs are 0, including `vme_cmd_rd`, `vme_dat_reg_out` and `err_count`.
  - State goes to IDLE.
  - `vme_cmd_rd`=1 from the first cycle after `rst` falls.
- States: IDLE, DECODE, STROBE, RESP, HOLDOFF.
- IDLE:
  - `vme_cmd_rd`=1.
  - On `start`=1: latch both input words, drop `vme_cmd_rd` next cycle, go to DECODE.
- DECODE (1 cycle):
  - Board address ≠ BOARD_ADDR: increment `err_count`, go to HOLDOFF, no `vme_dat_wr`.
  - Neither [25] nor [24] set: go to HOLDOFF, no response, no error.
  - [25]=1: read, regardless of [24].
  - Otherwise: write.
  - Drive `dev_sel`/`dev_addr`/`dev_wr`/`dev_wdata`, then go to STROBE.
- STROBE:
  - `dev_strobe`=1; address, select and data held stable.
  - Timeout counter starts at 0 on entry.
  - `dev_ack`=1 sampled: capture `dev_rdata` (read) or `dev_wdata` (write) into `vme_dat_reg_out[15:0]`, [31]=0, drop `dev_strobe` and `dev_sel`, go to RESP.
  - Counter reaches TIMEOUT_CYCLES without ack: `vme_dat_reg_out` = {1'b1, 15'b0, TIMEOUT_DATA}, increment `err_count`, go to RESP.
  - Ack arriving on the same cycle as the terminal count: ack wins, no error.
- RESP:
  - `vme_dat_wr`=1 for exactly one cycle, then go to HOLDOFF.
  - `vme_dat_reg_out` is held until the next response.
- HOLDOFF: HOLDOFF_CYCLES cycles with `vme_cmd_rd`=0, then IDLE.
- Latency, command to response: `start` sampled at cycle 0 → DECODE at 1 → strobe at 2 → ack at cycle 2+k → `vme_dat_wr` at 3+k → `vme_cmd_rd` high at 4+k+HOLDOFF_CYCLES.
- Flow control:
  - `start` while `vme_cmd_rd`=0 is ignored. No queuing, no error.
  - `dev_ack` outside STROBE is ignored.
- `err_count` saturates at 8'hFF. Cleared only by `rst`.
- `rst` mid-cycle: `dev_strobe`, `dev_sel`, `vme_dat_wr` drop on the next edge. Any pending response is discarded.

Test Plan:
- Read: cmd 32'h02A8_3010, device returns 16'h1234 with ack 3 cycles after strobe → `dev_sel`=16'h0008, `dev_addr`=12'h010, one `vme_dat_wr` with `vme_dat_reg_out`=32'h0000_1234, `vme_cmd_rd` high 2 cycles later.
- Write: cmd 32'h01A8_7004, data 32'h0000_BEEF, immediate ack → `dev_wr`=1, `dev_wdata`=16'hBEEF, `dev_sel`=16'h0080, response 32'h0000_BEEF.
- Board address mismatch: cmd 32'h02A9_3010 → no `dev_strobe`, no `vme_dat_wr`, `err_count`=1, `vme_cmd_rd` returns after HOLDOFF.
- Timeout: read with `dev_ack` never asserted → strobe held exactly 255 cycles, response 32'h8000_DEAD, `err_count` increments.
- Back-to-back and flow control:
  - Source holds `start`=1 continuously with 3 reads → exactly 3 responses in order; `start` during busy is ignored.
  - Both type bits set (32'h03A8_0000) → treated as read.
- Reset asserted during STROBE → next cycle `dev_strobe`=0, `vme_dat_wr`=0, `err_count`=0; `vme_cmd_rd`=1 one cycle after release.

Source files
------------

// File: rtl/vme_cmd_responder.sv
`default_nettype none
// ============================================================================
// Module      : vme_cmd_responder
// Description : Device-side end of the VME command channel. Accepts one
//               command/data word pair per start pulse, checks the board
//               address, runs a strobe/ack cycle on the device register bus
//               and returns the result with a one-cycle vme_dat_wr strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vme_cmd_responder #(
  parameter logic [7:0]  BOARD_ADDR     = 8'hA8,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          HOLDOFF_CYCLES = 2,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [31:0] vme_dat_reg_out,
  output logic [15:0] dev_sel,
  output logic [11:0] dev_addr,
  output logic        dev_wr,
  output logic        dev_strobe,
  output logic [15:0] dev_wdata,
  input  logic [15:0] dev_rdata,
  input  logic        dev_ack,
  output logic [7:0]  err_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
  // Last strobe cycle index: the strobe lasts exactly TIMEOUT_CYCLES cycles.
  localparam logic [TW-1:0] C_TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_STROBE  = 3'd2,
    S_RESP    = 3'd3,
    S_HOLDOFF = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [25:0]   cmd_q, cmd_d;
  logic [15:0]   wdat_q, wdat_d;
  logic          cmd_rd_q, cmd_rd_d;
  logic [31:0]   dat_out_q, dat_out_d;
  logic [15:0]   dev_sel_q, dev_sel_d;
  logic [11:0]   dev_addr_q, dev_addr_d;
  logic          dev_wr_q, dev_wr_d;
  logic [15:0]   dev_wdata_q, dev_wdata_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          err_inc;

  // Upper halves of the input words carry nothing for this block.
  logic unused_bits;
  assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

  // Next-state, datapath and error-count logic.
  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    wdat_d      = wdat_q;
    dat_out_d   = dat_out_q;
    dev_sel_d   = dev_sel_q;
    dev_addr_d  = dev_addr_q;
    dev_wr_d    = dev_wr_q;
    dev_wdata_d = dev_wdata_q;
    to_cnt_d    = to_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    err_inc     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // cmd_rd_q guards the first cycle after reset, when state is IDLE
        // but the source has not yet been told we are ready.
        if (start && cmd_rd_q) begin
          cmd_d   = vme_cmd_reg[25:0];
          wdat_d  = vme_dat_reg_in[15:0];
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        if (cmd_q[23:16] != BOARD_ADDR) begin
          err_inc    = 1'b1;
          hold_cnt_d = '0;
          state_d    = S_HOLDOFF;
        end else if (!cmd_q[25] && !cmd_q[24]) begin
          hold_cnt_d = '0;
          state_d    = S_HOLDOFF;
        end else begin
          // Read bit dominates when both type bits are set.
          dev_sel_d   = 16'd1 << cmd_q[15:12];
          dev_addr_d  = cmd_q[11:0];
          dev_wr_d    = !cmd_q[25];
          dev_wdata_d = wdat_q;
          to_cnt_d    = '0;
          state_d     = S_STROBE;
        end
      end

      S_STROBE: begin
        // Ack is checked first so an ack on the terminal count is not an error.
        if (dev_ack) begin
          dat_out_d = {16'h0000, (dev_wr_q ? dev_wdata_q : dev_rdata)};
          dev_sel_d = '0;
          state_d   = S_RESP;
        end else if (to_cnt_q == C_TO_LAST) begin
          dat_out_d = {1'b1, 15'b0, TIMEOUT_DATA};
          dev_sel_d = '0;
          err_inc   = 1'b1;
          state_d   = S_RESP;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_RESP: begin
        hold_cnt_d = '0;
        state_d    = S_HOLDOFF;
      end

      S_HOLDOFF: begin
        if (hold_cnt_q == C_HOLD_LAST) begin
          state_d = S_IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_count_d = err_count_q;
    if (err_inc && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    // Ready is registered from the next state so it is low during reset
    // and rises on the first edge after reset is released.
    cmd_rd_d = (state_d == S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      wdat_q      <= '0;
      cmd_rd_q    <= 1'b0;
      dat_out_q   <= '0;
      dev_sel_q   <= '0;
      dev_addr_q  <= '0;
      dev_wr_q    <= 1'b0;
      dev_wdata_q <= '0;
      to_cnt_q    <= '0;
      hold_cnt_q  <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      wdat_q      <= wdat_d;
      cmd_rd_q    <= cmd_rd_d;
      dat_out_q   <= dat_out_d;
      dev_sel_q   <= dev_sel_d;
      dev_addr_q  <= dev_addr_d;
      dev_wr_q    <= dev_wr_d;
      dev_wdata_q <= dev_wdata_d;
      to_cnt_q    <= to_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      err_count_q <= err_count_d;
    end
  end

  assign vme_cmd_rd      = cmd_rd_q;
  assign vme_dat_wr      = (state_q == S_RESP);
  assign vme_dat_reg_out = dat_out_q;
  assign dev_sel         = dev_sel_q;
  assign dev_addr        = dev_addr_q;
  assign dev_wr          = dev_wr_q;
  assign dev_strobe      = (state_q == S_STROBE);
  assign dev_wdata       = dev_wdata_q;
  assign err_count       = err_count_q;

endmodule
`default_nettype wire
